// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle ALU controller: funct/ALUOp codes,
// ALU operation codes, result-mux selects, FSM state type and decode record.
package alu_ctrl_pkg;

    localparam logic [5:0] FN_ADD  = 6'b010010;
    localparam logic [5:0] FN_SUB  = 6'b010000;
    localparam logic [5:0] FN_AND  = 6'b010100;
    localparam logic [5:0] FN_OR   = 6'b010110;
    localparam logic [5:0] FN_NOT  = 6'b010101;
    localparam logic [5:0] FN_SLT  = 6'b100000;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SH6  = 6'b000110;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b001010;
    localparam logic [5:0] FN_MFLO = 6'b001100;

    localparam logic [2:0] AOP_ADD_A = 3'b000;
    localparam logic [2:0] AOP_SUB_A = 3'b001;
    localparam logic [2:0] AOP_RTYPE = 3'b010;
    localparam logic [2:0] AOP_ADD_B = 3'b100;
    localparam logic [2:0] AOP_IMMUP = 3'b101;
    localparam logic [2:0] AOP_SUB_B = 3'b110;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SH6 = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOT = 4'b1010;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_SRL = 4'b0000;
    localparam logic [3:0] ALU_NOP = 4'b0000;

    localparam logic [1:0] FUR_ALU   = 2'd0;
    localparam logic [1:0] FUR_SHIFT = 2'd1;
    localparam logic [1:0] FUR_IMMUP = 2'd2;
    localparam logic [1:0] FUR_HILO  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] furslt;
        logic       jr;
        logic       hilo_sel;
        logic       is_md;
        logic       md_op;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_mc_if.sv
// Instruction-side and control-side signals of the ALU controller.
interface alu_ctrl_mc_if #(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3
);
    logic               valid_i;
    logic [FUNCT_W-1:0] funct_i;
    logic [ALUOP_W-1:0] ALUOp_i;
    logic               flush_i;
    logic [3:0]         ALU_operation_o;
    logic [1:0]         FURslt_o;
    logic               jr_o;
    logic               hilo_sel_o;
    logic               mdu_start_o;
    logic               mdu_op_o;
    logic               hilo_we_o;
    logic               stall_o;
    logic               illegal_o;

    modport master (
        output valid_i, funct_i, ALUOp_i, flush_i,
        input  ALU_operation_o, FURslt_o, jr_o, hilo_sel_o, mdu_start_o,
               mdu_op_o, hilo_we_o, stall_o, illegal_o
    );

    modport slave (
        input  valid_i, funct_i, ALUOp_i, flush_i,
        output ALU_operation_o, FURslt_o, jr_o, hilo_sel_o, mdu_start_o,
               mdu_op_o, hilo_we_o, stall_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Purely combinational decode of ALUOp/funct into ALU controls.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    output dec_t               dec_o
);

    always_comb begin
        dec_o = '0;
        case (aluop_i)
            ALUOP_W'(AOP_ADD_A), ALUOP_W'(AOP_ADD_B): dec_o.alu_op = ALU_ADD;
            ALUOP_W'(AOP_SUB_A), ALUOP_W'(AOP_SUB_B): dec_o.alu_op = ALU_SUB;
            ALUOP_W'(AOP_IMMUP): dec_o.furslt = FUR_IMMUP;
            ALUOP_W'(AOP_RTYPE): begin
                case (funct_i)
                    FUNCT_W'(FN_ADD):  dec_o.alu_op = ALU_ADD;
                    FUNCT_W'(FN_SUB):  dec_o.alu_op = ALU_SUB;
                    FUNCT_W'(FN_AND):  dec_o.alu_op = ALU_AND;
                    FUNCT_W'(FN_OR):   dec_o.alu_op = ALU_OR;
                    FUNCT_W'(FN_NOT):  dec_o.alu_op = ALU_NOT;
                    FUNCT_W'(FN_SLT):  dec_o.alu_op = ALU_SLT;
                    FUNCT_W'(FN_SLL): begin
                        dec_o.alu_op = ALU_SLL;
                        dec_o.furslt = FUR_SHIFT;
                    end
                    FUNCT_W'(FN_SRL): begin
                        dec_o.alu_op = ALU_SRL;
                        dec_o.furslt = FUR_SHIFT;
                    end
                    FUNCT_W'(FN_SH6):  dec_o.alu_op = ALU_SH6;
                    FUNCT_W'(FN_JR):   dec_o.jr = 1'b1;
                    FUNCT_W'(FN_MULT): dec_o.is_md = 1'b1;
                    FUNCT_W'(FN_DIV): begin
                        dec_o.is_md = 1'b1;
                        dec_o.md_op = 1'b1;
                    end
                    FUNCT_W'(FN_MFHI): begin
                        dec_o.furslt   = FUR_HILO;
                        dec_o.hilo_sel = 1'b1;
                    end
                    FUNCT_W'(FN_MFLO): dec_o.furslt = FUR_HILO;
                    default:           dec_o.illegal = 1'b1;
                endcase
            end
            default: dec_o.alu_op = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU controller with registered decode and a mult/div sequencing FSM that
// stalls the front end while the multiply/divide unit is busy.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    alu_ctrl_mc_if.slave bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT);

    dec_t             dec;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lat_load;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [1:0]       furslt_q, furslt_d;
    logic             jr_q, jr_d, hilo_sel_q, hilo_sel_d;
    logic             mdu_start_q, mdu_start_d, mdu_op_q, mdu_op_d;
    logic             illegal_q, illegal_d;
    logic             stall, accept, md_accept;

    alu_ctrl_dec #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W)) u_dec (
        .funct_i (bus.funct_i),
        .aluop_i (bus.ALUOp_i),
        .dec_o   (dec)
    );

    // Flush kills whatever is presented in the same cycle as well.
    assign stall     = (state_q == BUSY);
    assign accept    = bus.valid_i && !stall && !bus.flush_i;
    assign md_accept = accept && dec.is_md;
    assign lat_load  = dec.md_op ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_op_d    = alu_op_q;
        furslt_d    = furslt_q;
        hilo_sel_d  = hilo_sel_q;
        mdu_op_d    = mdu_op_q;
        jr_d        = 1'b0;
        illegal_d   = 1'b0;
        mdu_start_d = 1'b0;

        if (accept) begin
            alu_op_d   = dec.alu_op;
            furslt_d   = dec.furslt;
            hilo_sel_d = dec.hilo_sel;
            jr_d       = dec.jr;
            illegal_d  = dec.illegal;
            if (dec.is_md) begin
                mdu_start_d = 1'b1;
                mdu_op_d    = dec.md_op;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (md_accept) begin
                    state_d = BUSY;
                    cnt_d   = lat_load;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            alu_op_d    = '0;
            furslt_d    = '0;
            hilo_sel_d  = 1'b0;
            mdu_op_d    = 1'b0;
            jr_d        = 1'b0;
            illegal_d   = 1'b0;
            mdu_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_op_q    <= '0;
            furslt_q    <= '0;
            hilo_sel_q  <= 1'b0;
            mdu_op_q    <= 1'b0;
            jr_q        <= 1'b0;
            illegal_q   <= 1'b0;
            mdu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_op_q    <= alu_op_d;
            furslt_q    <= furslt_d;
            hilo_sel_q  <= hilo_sel_d;
            mdu_op_q    <= mdu_op_d;
            jr_q        <= jr_d;
            illegal_q   <= illegal_d;
            mdu_start_q <= mdu_start_d;
        end
    end

    assign bus.ALU_operation_o = alu_op_q;
    assign bus.FURslt_o        = furslt_q;
    assign bus.jr_o            = jr_q;
    assign bus.hilo_sel_o      = hilo_sel_q;
    assign bus.mdu_start_o     = mdu_start_q;
    assign bus.mdu_op_o        = mdu_op_q;
    assign bus.stall_o         = stall;
    assign bus.illegal_o       = illegal_q;
    // A flush landing in DONE must still cancel that cycle's HI/LO write.
    assign bus.hilo_we_o       = (state_q == DONE) && !bus.flush_i;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: directed scenarios plus randomized
// decode against a table-driven reference model.
module tb_alu_ctrl_mc;

    localparam int FUNCT_W = 6;
    localparam int ALUOP_W = 3;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    localparam logic [5:0] F_ADD  = 6'b010010;
    localparam logic [5:0] F_SUB  = 6'b010000;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_MFHI = 6'b001010;

    // {funct, alu_op, furslt, jr, hilo_sel, is_md, md_op}
    localparam logic [15:0] RTAB [14] = '{
        {6'b010010, 4'b0010, 2'd0, 4'b0000},
        {6'b010000, 4'b0110, 2'd0, 4'b0000},
        {6'b010100, 4'b0000, 2'd0, 4'b0000},
        {6'b010110, 4'b0001, 2'd0, 4'b0000},
        {6'b010101, 4'b1010, 2'd0, 4'b0000},
        {6'b100000, 4'b0111, 2'd0, 4'b0000},
        {6'b000000, 4'b0001, 2'd1, 4'b0000},
        {6'b000010, 4'b0000, 2'd1, 4'b0000},
        {6'b000110, 4'b0011, 2'd0, 4'b0000},
        {6'b001000, 4'b0000, 2'd0, 4'b1000},
        {6'b011000, 4'b0000, 2'd0, 4'b0010},
        {6'b011010, 4'b0000, 2'd0, 4'b0011},
        {6'b001010, 4'b0000, 2'd3, 4'b0100},
        {6'b001100, 4'b0000, 2'd3, 4'b0000}
    };
    // Non-R-type ALUOp values, indexed by ALUOp: {alu_op, furslt}
    localparam logic [5:0] ATAB [8] = '{
        6'b0010_00, 6'b0110_00, 6'b0000_00, 6'b0000_00,
        6'b0010_00, 6'b0000_10, 6'b0110_00, 6'b0000_00
    };

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_i = ~clk_i;

    alu_ctrl_mc_if #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W)) bus ();

    alu_ctrl_mc #(
        .FUNCT_W (FUNCT_W),
        .ALUOP_W (ALUOP_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // {alu_op[12:9], furslt[8:7], jr, hilo_sel, mdu_start, mdu_op, hilo_we, stall, illegal}
    function automatic logic [12:0] outs();
        return {bus.ALU_operation_o, bus.FURslt_o, bus.jr_o, bus.hilo_sel_o,
                bus.mdu_start_o, bus.mdu_op_o, bus.hilo_we_o, bus.stall_o, bus.illegal_o};
    endfunction

    function automatic logic [12:0] pack(input logic [3:0] op, input logic [1:0] fur,
                                         input logic jr, input logic hs, input logic st,
                                         input logic mo, input logic we, input logic sl,
                                         input logic il);
        return {op, fur, jr, hs, st, mo, we, sl, il};
    endfunction

    task automatic ref_dec(input logic [2:0] aop, input logic [5:0] fn,
                           output logic [3:0] op, output logic [1:0] fur,
                           output logic jr, output logic hs, output logic ill,
                           output logic md, output logic mdop);
        logic [15:0] e;
        logic [5:0]  a;
        op = '0; fur = '0; jr = 1'b0; hs = 1'b0; ill = 1'b0; md = 1'b0; mdop = 1'b0;
        if (aop != 3'b010) begin
            a   = ATAB[aop];
            op  = a[5:2];
            fur = a[1:0];
        end else begin
            ill = 1'b1;
            for (int i = 0; i < 14; i++) begin
                e = RTAB[i];
                if (e[15:10] == fn) begin
                    ill = 1'b0; op = e[9:6]; fur = e[5:4];
                    jr = e[3]; hs = e[2]; md = e[1]; mdop = e[0];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] aop, input logic [5:0] fn,
                         input logic fl);
        bus.valid_i = v;
        bus.ALUOp_i = aop;
        bus.funct_i = fn;
        bus.flush_i = fl;
    endtask

    task automatic settle();
        drive(1'b0, 3'b000, 6'b000000, 1'b1);
        tick();
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst_i = 1'b0;
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
        tick();
        tick();
        got = outs();
        n_tests++;
        if (got !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", got, 13'b0);
        end
        drive(1'b1, 3'b010, F_ADD, 1'b0);
        tick();
        got = outs();
        n_tests++;
        if (got !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_holds got=%b exp=%b", got, 13'b0);
        end
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_sub();
        logic [12:0] got, exp;
        settle();
        drive(1'b1, 3'b010, F_SUB, 1'b0);
        tick();
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
        got = outs();
        exp = pack(4'b0110, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL sub_decode got=%b exp=%b", got, exp);
        end
    endtask

    task automatic test_mult();
        logic [12:0] got, exp;
        settle();
        drive(1'b1, 3'b010, F_MULT, 1'b0);
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            tick();
            if (k == 0) drive(1'b0, 3'b000, 6'b000000, 1'b0);
            got = outs();
            exp = pack(4'b0, 2'd0, 0, 0, k == 0, 0, k == MUL_LAT - 1, k < MUL_LAT - 1, 0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mult_seq k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_div_mfhi();
        logic [12:0] got, exp;
        logic        hi;
        settle();
        drive(1'b1, 3'b010, F_DIV, 1'b0);
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            tick();
            got = outs();
            hi  = (k >= DIV_LAT);
            exp = pack(4'b0, hi ? 2'd3 : 2'd0, 0, hi, k == 0, 1,
                       k == DIV_LAT - 1, k < DIV_LAT - 1, 0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL div_mfhi k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k == 0) drive(1'b1, 3'b010, F_MFHI, 1'b0);
            if (k == DIV_LAT) drive(1'b0, 3'b000, 6'b000000, 1'b0);
        end
    endtask

    task automatic test_flush_expiry();
        logic [12:0] got, exp;
        settle();
        drive(1'b1, 3'b010, F_DIV, 1'b0);
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            tick();
            got = outs();
            if (k <= DIV_LAT - 2) exp = pack(4'b0, 2'd0, 0, 0, k == 0, 1, 0, 1, 0);
            else                  exp = 13'b0;
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush_expiry k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k == 0)           drive(1'b0, 3'b000, 6'b000000, 1'b0);
            if (k == DIV_LAT - 2) drive(1'b0, 3'b000, 6'b000000, 1'b1);
            if (k == DIV_LAT - 1) drive(1'b0, 3'b000, 6'b000000, 1'b0);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [12:0] got, exp;
        settle();
        drive(1'b1, 3'b010, F_DIV, 1'b0);
        tick();
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        got = outs();
        n_tests++;
        if (got !== 13'b0) begin
            n_fail++;
            $display("FAIL rst_async got=%b exp=%b", got, 13'b0);
        end
        tick();
        rst_i = 1'b1;
        drive(1'b1, 3'b010, F_ADD, 1'b0);
        tick();
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
        exp = pack(4'b0010, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            got = outs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rst_then_add k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_illegal_jr();
        logic [12:0] got, exp;
        settle();
        drive(1'b1, 3'b010, 6'b111111, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            drive(1'b0, 3'b000, 6'b000000, 1'b0);
            got = outs();
            exp = pack(4'b0, 2'd0, 0, 0, 0, 0, 0, 0, k == 0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL illegal_pulse k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        drive(1'b1, 3'b010, F_JR, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            drive(1'b0, 3'b000, 6'b000000, 1'b0);
            got = outs();
            exp = pack(4'b0, 2'd0, k == 0, 0, 0, 0, 0, 0, 0);
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL jr_pulse k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] got, exp;
        int          p;
        settle();
        drive(1'b1, 3'b010, F_MULT, 1'b0);
        for (int k = 0; k < 2 * MUL_LAT + 2; k++) begin
            tick();
            got = outs();
            p   = k % MUL_LAT;
            if (k < 2 * MUL_LAT)
                exp = pack(4'b0, 2'd0, 0, 0, p == 0, 0, p == MUL_LAT - 1, p < MUL_LAT - 1, 0);
            else
                exp = 13'b0;
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k == 2 * MUL_LAT - 1) drive(1'b0, 3'b000, 6'b000000, 1'b0);
        end
    endtask

    task automatic test_random_decode();
        logic [12:0] got, exp;
        logic [3:0]  op, e_op;
        logic [1:0]  fur, e_fur;
        logic        jr, hs, ill, md, mdop, e_hs, v, fl;
        logic [2:0]  aop;
        logic [5:0]  fn;
        logic [15:0] ent;
        settle();
        e_op = '0; e_fur = '0; e_hs = 1'b0;
        for (int n = 0; n < 80; n++) begin
            aop = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) aop = 3'b010;
            ent = RTAB[$urandom_range(0, 13)];
            fn  = ($urandom_range(0, 1) == 0) ? ent[15:10] : 6'($urandom);
            ref_dec(aop, fn, op, fur, jr, hs, ill, md, mdop);
            if (md) begin
                fn = F_ADD;
                ref_dec(aop, fn, op, fur, jr, hs, ill, md, mdop);
            end
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 9) == 0);
            drive(v, aop, fn, fl);
            tick();
            if (fl) begin
                e_op = '0; e_fur = '0; e_hs = 1'b0;
                exp  = 13'b0;
            end else if (v) begin
                e_op = op; e_fur = fur; e_hs = hs;
                exp  = pack(op, fur, jr, hs, 0, 0, 0, 0, ill);
            end else begin
                exp  = pack(e_op, e_fur, 0, e_hs, 0, 0, 0, 0, 0);
            end
            got = outs();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand_decode n=%0d aop=%b fn=%b v=%b fl=%b got=%b exp=%b",
                         n, aop, fn, v, fl, got, exp);
            end
        end
        drive(1'b0, 3'b000, 6'b000000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_mult();
        test_div_mfhi();
        test_flush_expiry();
        test_reset_mid_busy();
        test_illegal_jr();
        test_back_to_back();
        test_random_decode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mc.md
ALU_CTRL_MC -- requirements
Module: alu_ctrl_mc

Interface
REQ-001 SHALL have parameter FUNCT_W, default 6, width of the funct field.
REQ-002 SHALL have parameter ALUOP_W, default 3, width of the main-decoder ALUOp field.
REQ-003 SHALL have parameter MUL_LAT, default 4, number of cycles the multiply/divide unit needs for mult.
REQ-004 SHALL have parameter DIV_LAT, default 8, number of cycles the multiply/divide unit needs for div; MUL_LAT and DIV_LAT SHALL each be at least 2.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-low.
REQ-006 SHALL have ports: valid_i in 1, instruction present; funct_i in FUNCT_W; ALUOp_i in ALUOP_W; flush_i in 1, kill the in-flight operation.
REQ-007 SHALL have ports: ALU_operation_o out 4; FURslt_o out 2 (0 ALU, 1 shifter, 2 immediate-upper, 3 HI/LO); jr_o out 1; hilo_sel_o out 1 (1 HI, 0 LO).
REQ-008 SHALL have ports: mdu_start_o out 1; mdu_op_o out 1 (0 mult, 1 div); hilo_we_o out 1; stall_o out 1; illegal_o out 1.

Function
REQ-009 SHALL register all decode outputs, with 1-cycle latency from an accepted instruction to its outputs; accept = valid_i & ~stall_o.
REQ-010 SHALL decode ALUOp_i=010 by funct: 010010 add->0010; 010000 sub->0110; 010100 and->0000; 010110 or->0001; 010101 not->1010; 100000 slt->0111.
REQ-011 SHALL decode shifts: 000000 sll->0001 with FURslt 1; 000010 srl->0000 with FURslt 1; 000110->0011 with FURslt 0.
REQ-012 SHALL decode 001000 jr as jr_o=1 for one cycle, ALU_operation 0000, FURslt 0.
REQ-013 SHALL decode new funct codes: 011000 mult, 011010 div, 001010 mfhi (FURslt 3, hilo_sel 1), 001100 mflo (FURslt 3, hilo_sel 0).
REQ-014 SHALL decode the other ALUOp values: 000 and 100 -> 0010, FURslt 0; 001 and 110 -> 0110; 101 -> FURslt 2, ALU_operation 0000; any other value -> 0000.
REQ-015 SHALL drive ALU_operation 0000 and FURslt 0 for an accepted ALUOp=010 with an undefined funct, and pulse illegal_o for 1 cycle.
REQ-016 SHALL use an FSM with states IDLE, BUSY and DONE.
REQ-017 On an accepted mult or div, the FSM SHALL go IDLE/DONE->BUSY, pulse mdu_start_o for 1 cycle, drive mdu_op_o, and load the down-counter with LAT-2.
REQ-018 In BUSY, the down-counter SHALL decrement each cycle; at 0 the FSM SHALL go to DONE; stall_o SHALL be high exactly while in BUSY (combinational from state).
REQ-019 DONE SHALL last 1 cycle with hilo_we_o=1, then go to IDLE, or to BUSY if a new mult/div is accepted that cycle.
REQ-020 Total stall for mult SHALL be MUL_LAT-1 cycles; total stall for div SHALL be DIV_LAT-1 cycles.
REQ-021 While stall_o=1, instruction inputs SHALL be ignored; upstream holds them.
REQ-022 flush_i in BUSY or DONE SHALL force IDLE next cycle and suppress hilo_we_o; flush SHALL win over a simultaneous counter expiry.
REQ-023 flush_i SHALL clear the registered decode outputs to their reset values.
REQ-024 SHALL register an mfhi/mflo issued immediately after a mult/div only after DONE, because the stall enforces it.

Reset
REQ-025 On rst_i=0, the FSM SHALL go to IDLE, the counter to 0, and all outputs to 0 (ALU_operation_o=0000, FURslt_o=0), asynchronously.
REQ-026 Reset asserted mid-BUSY SHALL abandon the operation with no hilo_we_o pulse; the first cycle after release SHALL accept instructions.

Structure
REQ-027 SHALL place funct codes, ALUOp codes, ALU operation codes, FURslt encodings and the FSM state type in shared package alu_ctrl_pkg.
REQ-028 SHALL keep the combinational decode table in sub-module alu_ctrl_dec; alu_ctrl_mc holds the FSM, counter and output registers.

Verification
REQ-029 The bench SHALL check: ALUOp=010, funct=010000, valid=1 -> next cycle ALU_operation_o=0110, FURslt_o=0, stall_o=0.
REQ-030 The bench SHALL check: mult with MUL_LAT=4 -> mdu_start_o 1 cycle, mdu_op_o=0, stall_o high 3 cycles, hilo_we_o 1 cycle, then IDLE.
REQ-031 The bench SHALL check: div (DIV_LAT=8) followed by a held mfhi -> stall 7 cycles, mfhi registered only after DONE, FURslt_o=3, hilo_sel_o=1.
REQ-032 The bench SHALL check: flush_i asserted on the cycle the counter reaches 0 -> no hilo_we_o, IDLE next cycle, outputs 0.
REQ-033 The bench SHALL check: rst_i low for 1 cycle mid-BUSY -> all outputs 0 immediately, stall_o=0, a following add decodes 0010.
REQ-034 The bench SHALL check: funct=111111 with ALUOp=010 -> illegal_o 1-cycle pulse, ALU_operation_o=0000; jr funct=001000 -> jr_o 1-cycle pulse.
